// File: rtl/fifo_burst_reader_if.sv
// Read-side bundle for fifo_burst_reader: FIFO read port plus the outgoing valid/ready stream.
// The master side is the burst reader; the slave side is the FIFO and the downstream sink.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Read_enable;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output Read_enable, m_data, m_valid,
    input  fifo_empty, fifo_data, m_ready
  );

  modport slave (
    input  Read_enable, m_data, m_valid,
    output fifo_empty, fifo_data, m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: drains a programmed word count from the FIFO into a 2-entry skid buffer stream.
// Optional empty-stall abort is built only when BURST_TIMEOUT_EN is defined.
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_read,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  fifo_burst_reader_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
    return (v >= MAX_LEN) ? MAX_LEN : v + LEN_ONE;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] head_data_p2, tail_data_p2;
  logic                  head_vld_p2, tail_vld_p2;
  logic                  pop, credit_ok, drained, rd_en, timeout_hit, accept;
  logic [2:0]            outstanding;

  assign accept = (state_q == IDLE) && start;
  assign pop    = head_vld_p2 && bus.m_ready;

  // Words in flight or buffered after this cycle's pop; a new read must leave room in the skid.
  assign outstanding = 3'(vld_p1) + 3'(head_vld_p2) + 3'(tail_vld_p2) - 3'(pop);
  assign credit_ok   = outstanding < 3'd2;
  assign drained     = !vld_p1 && (!head_vld_p2 || (pop && !tail_vld_p2));

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_cnt_q;
  logic          timeout_q;
  logic          stalled;

  assign stalled     = (state_q == READ) && bus.fifo_empty && (remaining_q != '0);
  assign timeout_hit = stalled && (stall_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (accept) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (rd_en) begin
      stall_cnt_q <= '0;
    end else if (timeout_hit) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b1;
    end else if (stalled) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (burst_len == '0) ? DONE : READ;
      READ:    if (timeout_hit || (remaining_q == '0) || (rd_en && remaining_q == LEN_ONE))
                 state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state_q == READ) && !bus.fifo_empty && (remaining_q != '0) && credit_ok;
  end

  assign bus.Read_enable = rd_en;

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      remaining_q <= '0;
      word_count  <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      if (accept)           remaining_q <= clamp_len(burst_len);
      else if (timeout_hit) remaining_q <= '0;
      else if (rd_en)       remaining_q <= remaining_q - LEN_ONE;
      if (accept)   word_count <= '0;
      else if (pop) word_count <= sat_inc(word_count);
    end
  end

  // p1: read issued last cycle, FIFO data valid now
  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_en;
  end

  // p2: skid buffer, head entry drives the stream
  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      head_vld_p2  <= 1'b0;
      tail_vld_p2  <= 1'b0;
      head_data_p2 <= '0;
      tail_data_p2 <= '0;
    end else begin
      case ({vld_p1, pop})
        2'b11: begin
          if (tail_vld_p2) begin
            head_data_p2 <= tail_data_p2;
            tail_data_p2 <= bus.fifo_data;
          end else begin
            head_data_p2 <= bus.fifo_data;
          end
        end
        2'b01: begin
          head_data_p2 <= tail_data_p2;
          head_vld_p2  <= tail_vld_p2;
          tail_vld_p2  <= 1'b0;
        end
        2'b10: begin
          if (!head_vld_p2) begin
            head_data_p2 <= bus.fifo_data;
            head_vld_p2  <= 1'b1;
          end else begin
            tail_data_p2 <= bus.fifo_data;
            tail_vld_p2  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_data  = head_data_p2;
  assign bus.m_valid = head_vld_p2;

endmodule
